// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control unit: Moore FSM that sequences fetch, decode, memory,
// ALU and branch steps, evaluates conditions and keeps NZ/CV flag state.
module multicycle_control_unit #(
  parameter int ALUC_W = 3,
  parameter int BL_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [19:0]       Instr,
  input  logic [3:0]        ALUFlags,
  output logic              PCWrite,
  output logic              IRWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              LinkWrite,
  output logic              AdrSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              Undef,
  output logic [3:0]        State
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;

  localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(0);
  localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(1);
  localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(2);
  localparam logic [ALUC_W-1:0] ALU_ORR = ALUC_W'(3);
  localparam logic [ALUC_W-1:0] ALU_MOV = ALUC_W'(4);

  if (ALUC_W < 3) begin : g_aluc_w_check
    $error("multicycle_control_unit: ALUC_W must be at least 3");
  end

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign cmd       = funct[4:1];
  assign unused_rn = ^Instr[7:4];

  logic [3:0] state_q, state_d;
  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       cond_ex_r_q, cond_ex_r_d;

  logic                flag_n, flag_z, flag_c, flag_v;
  logic                cond_ex;
  logic [ALUC_W-1:0]   dp_alu;
  logic                dp_legal;
  logic                dp_arith;
  logic                dp_no_wb;
  logic                undef_dec;
  logic                is_exec;
  logic                rd_is_pc;

  assign flag_n = nz_q[1];
  assign flag_z = nz_q[0];
  assign flag_c = cv_q[1];
  assign flag_v = cv_q[0];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    dp_alu   = ALU_ADD;
    dp_legal = 1'b1;
    case (cmd)
      4'b0100:          dp_alu = ALU_ADD;
      4'b0010, 4'b1010: dp_alu = ALU_SUB;
      4'b0000, 4'b1000: dp_alu = ALU_AND;
      4'b1100:          dp_alu = ALU_ORR;
      4'b1101:          dp_alu = ALU_MOV;
      default:          dp_legal = 1'b0;
    endcase
  end

  // CMP and TST only produce flags, so they skip the write-back step.
  assign dp_arith  = (cmd == 4'b0100) | (cmd == 4'b0010) | (cmd == 4'b1010);
  assign dp_no_wb  = (cmd == 4'b1010) | (cmd == 4'b1000);
  assign undef_dec = (op == 2'b11) | ((op == 2'b00) & ~dp_legal);
  assign is_exec   = (state_q == EXECR) | (state_q == EXECI);
  assign rd_is_pc  = (rd == 4'b1111);

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (undef_dec)         state_d = FETCH;
        else if (op == 2'b01)  state_d = MEMADR;
        else if (op == 2'b10)  state_d = BRANCH;
        else if (op == 2'b00)  state_d = funct[5] ? EXECI : EXECR;
        else                   state_d = FETCH;
      end
      MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR,
      EXECI:  state_d = dp_no_wb ? FETCH : ALUWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    nz_d        = nz_q;
    cv_d        = cv_q;
    cond_ex_r_d = cond_ex_r_q;
    if (state_q == DECODE) cond_ex_r_d = cond_ex;
    if (is_exec && cond_ex_r_q && funct[0]) begin
      nz_d = ALUFlags[3:2];
      if (dp_arith) cv_d = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      nz_q        <= 2'b00;
      cv_q        <= 2'b00;
      cond_ex_r_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nz_q        <= nz_d;
      cv_q        <= cv_d;
      cond_ex_r_q <= cond_ex_r_d;
    end
  end

  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (op)
      2'b01: begin
        ImmSrc = 2'b01;
        RegSrc = funct[0] ? 2'b00 : 2'b10;
      end
      2'b10: begin
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
      end
      default: ;
    endcase
  end

  // Write enables are masked while reset is high so nothing commits mid-abort.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    LinkWrite  = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    Undef      = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        Undef     = undef_dec;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_r_q;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex_r_q;
        PCWrite   = cond_ex_r_q & rd_is_pc;
      end
      EXECR: ALUControl = dp_alu;
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dp_alu;
      end
      ALUWB: begin
        RegWrite = cond_ex_r_q;
        PCWrite  = cond_ex_r_q & rd_is_pc;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex_r_q;
        LinkWrite = cond_ex_r_q & funct[4] & (BL_EN != 0);
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      LinkWrite = 1'b0;
      Undef     = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench for multicycle_control_unit: per-cycle expectations are
// queued as each instruction is issued, then popped and compared every cycle.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;

  logic       PCWrite, IRWrite, RegWrite, MemWrite, LinkWrite, AdrSrc, ALUSrcA, Undef;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  logic       PCWrite_b, IRWrite_b, RegWrite_b, MemWrite_b, LinkWrite_b, Undef_b;
  logic       unused_b_adrsrc, unused_b_srca;
  logic [1:0] unused_b_srcb, unused_b_res, unused_b_imm, unused_b_reg;
  logic [2:0] unused_b_aluc;
  logic [3:0] State_b;

  multicycle_control_unit #(.ALUC_W(3), .BL_EN(1)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .LinkWrite(LinkWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Undef(Undef), .State(State)
  );

  multicycle_control_unit #(.ALUC_W(3), .BL_EN(0)) dut_nobl (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite_b), .IRWrite(IRWrite_b), .RegWrite(RegWrite_b), .MemWrite(MemWrite_b),
    .LinkWrite(LinkWrite_b), .AdrSrc(unused_b_adrsrc), .ALUSrcA(unused_b_srca),
    .ALUSrcB(unused_b_srcb), .ResultSrc(unused_b_res), .ImmSrc(unused_b_imm),
    .RegSrc(unused_b_reg), .ALUControl(unused_b_aluc), .Undef(Undef_b), .State(State_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       lw;
    logic       lwb;
    logic       und;
    int         aluc;
  } exp_t;

  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cur_imm;
  int    cur_rs;
  string cur_name;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s %s: observed %0h, expected %0h", cur_name, tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] exp_srcb(input logic [3:0] st);
    case (st)
      4'd0, 4'd1:       return 2'b10;
      4'd2, 4'd7, 4'd9: return 2'b01;
      default:          return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_res(input logic [3:0] st);
    case (st)
      4'd0, 4'd1, 4'd9: return 2'b10;
      4'd4:             return 2'b01;
      default:          return 2'b00;
    endcase
  endfunction

  task automatic ex(input logic [3:0] st, input logic pcw, input logic rw, input logic mw,
                    input logic lw, input logic lwb, input logic und, input int aluc);
    exp_t e;
    e.st = st; e.pcw = pcw; e.rw = rw; e.mw = mw;
    e.lw = lw; e.lwb = lwb; e.und = und; e.aluc = aluc;
    sb.push_back(e);
  endtask

  // Every instruction opens with FETCH (PCWrite, ADD) then DECODE.
  task automatic issue(input string name, input logic [19:0] ins, input logic [3:0] flags,
                       input int imm, input int rs, input logic und);
    cur_name = name;
    Instr    = ins;
    ALUFlags = flags;
    cur_imm  = imm;
    cur_rs   = rs;
    ex(4'd0, 1, 0, 0, 0, 0, 0, 0);
    ex(4'd1, 0, 0, 0, 0, 0, und, -1);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      #1;
      e = sb.pop_front();
      chk("State", State, e.st);
      chk("PCWrite", PCWrite, e.pcw);
      chk("IRWrite", IRWrite, e.st == 4'd0);
      chk("RegWrite", RegWrite, e.rw);
      chk("MemWrite", MemWrite, e.mw);
      chk("LinkWrite", LinkWrite, e.lw);
      chk("Undef", Undef, e.und);
      chk("ALUSrcA", ALUSrcA, e.st <= 4'd1);
      chk("ALUSrcB", ALUSrcB, exp_srcb(e.st));
      chk("ResultSrc", ResultSrc, exp_res(e.st));
      chk("AdrSrc", AdrSrc, (e.st == 4'd3) || (e.st == 4'd5));
      chk("State_nobl", State_b, e.st);
      chk("PCWrite_nobl", PCWrite_b, e.pcw);
      chk("RegWrite_nobl", RegWrite_b, e.rw);
      chk("MemWrite_nobl", MemWrite_b, e.mw);
      chk("LinkWrite_nobl", LinkWrite_b, e.lwb);
      chk("IRWrite_nobl", IRWrite_b, e.st == 4'd0);
      chk("Undef_nobl", Undef_b, e.und);
      if (e.aluc >= 0) chk("ALUControl", ALUControl, e.aluc);
      if (cur_imm >= 0) chk("ImmSrc", ImmSrc, cur_imm);
      if (cur_rs >= 0) chk("RegSrc", RegSrc, cur_rs);
      @(negedge clk);
    end
  endtask

  initial begin
    reset    = 1'b1;
    Instr    = 20'h0;
    ALUFlags = 4'h0;
    cur_imm  = -1;
    cur_rs   = -1;
    cur_name = "reset";
    #2;
    chk("State", State, 4'd0);
    chk("PCWrite", PCWrite, 1'b0);
    chk("IRWrite", IRWrite, 1'b0);
    chk("RegWrite", RegWrite, 1'b0);
    chk("MemWrite", MemWrite, 1'b0);
    chk("LinkWrite", LinkWrite, 1'b0);
    chk("Undef", Undef, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    issue("add", 20'hE0821, 4'b0000, 0, 0, 0);
    ex(4'd6, 0, 0, 0, 0, 0, 0, 0);
    ex(4'd8, 0, 1, 0, 0, 0, 0, -1);
    drain();

    issue("add_pc", 20'hE082F, 4'b0000, 0, 0, 0);
    ex(4'd6, 0, 0, 0, 0, 0, 0, 0);
    ex(4'd8, 1, 1, 0, 0, 0, 0, -1);
    drain();

    issue("sub", 20'hE0421, 4'b0000, 0, 0, 0);
    ex(4'd6, 0, 0, 0, 0, 0, 0, 1);
    ex(4'd8, 0, 1, 0, 0, 0, 0, -1);
    drain();

    issue("orr", 20'hE1821, 4'b0000, 0, 0, 0);
    ex(4'd6, 0, 0, 0, 0, 0, 0, 3);
    ex(4'd8, 0, 1, 0, 0, 0, 0, -1);
    drain();

    issue("mov", 20'hE1A01, 4'b0000, 0, 0, 0);
    ex(4'd6, 0, 0, 0, 0, 0, 0, 4);
    ex(4'd8, 0, 1, 0, 0, 0, 0, -1);
    drain();

    issue("eor_undef", 20'hE0221, 4'b0000, 0, 0, 1);
    drain();

    issue("ldr", 20'hE5910, 4'b0000, 1, 0, 0);
    ex(4'd2, 0, 0, 0, 0, 0, 0, 0);
    ex(4'd3, 0, 0, 0, 0, 0, 0, -1);
    ex(4'd4, 0, 1, 0, 0, 0, 0, -1);
    drain();

    issue("str", 20'hE5810, 4'b0000, 1, 2, 0);
    ex(4'd2, 0, 0, 0, 0, 0, 0, 0);
    ex(4'd5, 0, 0, 1, 0, 0, 0, -1);
    drain();

    issue("cmp_z", 20'hE3500, 4'b0100, 0, 0, 0);
    ex(4'd7, 0, 0, 0, 0, 0, 0, 1);
    drain();

    issue("beq_taken", 20'h0A000, 4'b1011, 2, 1, 0);
    ex(4'd9, 1, 0, 0, 0, 0, 0, 0);
    drain();

    issue("tst_clr", 20'hE3100, 4'b0000, 0, 0, 0);
    ex(4'd7, 0, 0, 0, 0, 0, 0, 2);
    drain();

    issue("beq_not", 20'h0A000, 4'b0100, 2, 1, 0);
    ex(4'd9, 0, 0, 0, 0, 0, 0, 0);
    drain();

    issue("bne_taken", 20'h1A000, 4'b0000, 2, 1, 0);
    ex(4'd9, 1, 0, 0, 0, 0, 0, 0);
    drain();

    issue("cmp_c", 20'hE3500, 4'b0010, 0, 0, 0);
    ex(4'd7, 0, 0, 0, 0, 0, 0, 1);
    drain();

    issue("tst_keep_cv", 20'hE3100, 4'b0000, 0, 0, 0);
    ex(4'd7, 0, 0, 0, 0, 0, 0, 2);
    drain();

    issue("bcs_taken", 20'h2A000, 4'b0000, 2, 1, 0);
    ex(4'd9, 1, 0, 0, 0, 0, 0, 0);
    drain();

    issue("bl", 20'hEB000, 4'b0000, 2, 1, 0);
    ex(4'd9, 1, 0, 0, 1, 0, 0, 0);
    drain();

    issue("cmp_z2", 20'hE3500, 4'b0100, 0, 0, 0);
    ex(4'd7, 0, 0, 0, 0, 0, 0, 1);
    drain();

    issue("addne", 20'h10821, 4'b0000, 0, 0, 0);
    ex(4'd6, 0, 0, 0, 0, 0, 0, 0);
    ex(4'd8, 0, 0, 0, 0, 0, 0, -1);
    drain();

    issue("addsne", 20'h10921, 4'b0000, 0, 0, 0);
    ex(4'd6, 0, 0, 0, 0, 0, 0, 0);
    ex(4'd8, 0, 0, 0, 0, 0, 0, -1);
    drain();

    issue("beq_z_kept", 20'h0A000, 4'b0000, 2, 1, 0);
    ex(4'd9, 1, 0, 0, 0, 0, 0, 0);
    drain();

    issue("op11", 20'hEC000, 4'b0000, -1, -1, 1);
    drain();

    issue("cmp_z3", 20'hE3500, 4'b0100, 0, 0, 0);
    ex(4'd7, 0, 0, 0, 0, 0, 0, 1);
    drain();

    issue("str_abort", 20'hE5810, 4'b0000, 1, 2, 0);
    ex(4'd2, 0, 0, 0, 0, 0, 0, 0);
    drain();
    #1;
    chk("State_memwr", State, 4'd5);
    chk("MemWrite_memwr", MemWrite, 1'b1);
    reset = 1'b1;
    #1;
    chk("MemWrite_rst", MemWrite, 1'b0);
    chk("State_rst", State, 4'd0);
    chk("PCWrite_rst", PCWrite, 1'b0);
    chk("IRWrite_rst", IRWrite, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    issue("beq_after_rst", 20'h0A000, 4'b0000, 2, 1, 0);
    ex(4'd9, 0, 0, 0, 0, 0, 0, 0);
    drain();
    #1;
    chk("State_end", State, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
